mac_row_ctrl: RTL
=================

Name: mac_row_ctrl

Overview:
Sequencer for one mac_row. On a start pulse it streams col kernel weights from a scratch memory with inst_w=01 (kernel load), then streams len activations with inst_w=10 (execute). It then waits for the row's last-column valid to report len results and signals done. It sits between the top-level control and a mac_row instance, and owns the memory read port that feeds in_w.

Parameters:
bw, 4, width of a weight/activation word (matches mac_row bw)
col, 8, number of MAC columns in the driven row
addr_bw, 8, memory address width
len_bw, 8, width of activation count and result counter
drain_max, 16, max cycles allowed in DRAIN before error abort

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
start  input  1  1-cycle request, accepted only in IDLE
len  input  len_bw  number of activation words to execute, sampled at start
w_base  input  addr_bw  weight base address, sampled at start
x_base  input  addr_bw  activation base address, sampled at start
mem_rd  output  1  memory read enable
mem_addr  output  addr_bw  memory read address
mem_q  input  bw  memory read data, valid 1 cycle after mem_rd
in_w  output  bw  to mac_row in_w
inst_w  output  2  to mac_row inst_w (01 load, 10 execute, 00 idle)
row_valid  input  col  from mac_row valid
busy  output  1  high in LOAD/EXEC/DRAIN
done  output  1  1-cycle completion pulse
err  output  1  high with done when DRAIN timed out
out_cnt  output  len_bw  results seen on row_valid[col-1] in current job

Behaviour:
- Reset (sync, highest priority, also mid-job): state=IDLE; mem_rd=0, mem_addr=0, in_w=0, inst_w=00, busy=0, done=0, err=0, out_cnt=0; phase pipe cleared. No partial job survives.
- FSM states: IDLE, LOAD, EXEC, DRAIN, DONE.
- IDLE: start=1 -> latch len/w_base/x_base, clear out_cnt and err, go to LOAD. start ignored in every other state, including DONE.
- LOAD: mem_rd=1, mem_addr=w_base+k for k=0..col-1, one per cycle. After col cycles go to EXEC if len!=0, else go to DRAIN.
- EXEC: mem_rd=1, mem_addr=x_base+j for j=0..len-1, back-to-back with no bubble after the last weight read. Then go to DRAIN.
- Address arithmetic is modulo 2^addr_bw (wrap from all-ones to 0 is legal).
- Phase pipe: a registered copy of {load,exec} read phase, delayed 1 cycle.
  - inst_w = 01 or 10 one cycle after the corresponding read; in_w = mem_q in those cycles.
  - Otherwise inst_w=00 and in_w=0.
- Timeline for start accepted at cycle 0:
  - reads at cycles 1..col+len
  - inst_w=01 at cycles 2..col+1
  - inst_w=10 at cycles col+2..col+len+1
  - first DRAIN cycle = col+len+1
- out_cnt increments by 1 on every cycle with busy=1 and row_valid[col-1]=1. It saturates at 2^len_bw-1 and holds its value after done until the next accepted start.
- DRAIN: mem_rd=0.
  - out_cnt>=len -> DONE with err=0.
  - drain_max cycles in DRAIN without reaching len -> DONE with err=1.
  - len=0 exits on the first DRAIN cycle.
- DONE: done=1 for exactly one cycle, busy=0, err valid; next state IDLE.
- busy and done are never high together.

Test Plan:
- Reset, then start with w_base=0x10, x_base=0x20, len=3, col=8: reads 0x10..0x17 then 0x20..0x22 at cycles 1..11; inst_w=01 cycles 2..9 and 10 cycles 10..12; in_w equals memory contents one cycle late.
- Model row_valid[col-1] high for 3 cycles after the execute burst: out_cnt=3, single done pulse, err=0, busy falls the same cycle done rises.
- len=0: only 8 weight reads occur, inst_w=10 never appears, done 2 cycles after the last load read, out_cnt=0, err=0.
- w_base=0xFE, col=8: addresses 0xFE,0xFF,0x00..0x05 (wrap); second start pulsed during EXEC is ignored, with no extra reads and one done.
- row_valid held 0: done with err=1 exactly drain_max cycles after DRAIN entry; the next job clears err at start.
- reset asserted mid-EXEC: next cycle all outputs 0 and state IDLE; a fresh start afterwards runs a full correct job.

Source files
------------

// File: rtl/mac_row_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mac_row_ctrl
//  Description : Job sequencer for a single mac_row. A start pulse, accepted
//                only in IDLE, triggers:
//                  1. COL weight reads from w_base, presented as kernel load.
//                  2. len activation reads from x_base, presented as execute.
//                  3. A drain phase that waits until len results are seen on
//                     the row's last-column valid.
//                Done is a single-cycle pulse. If the drain phase runs for
//                DRAIN_MAX cycles first, err is raised alongside done.
//
//  Ports       : clk, reset           clock and synchronous active-high reset
//                start, len,          job request; len, w_base and x_base
//                w_base, x_base       are captured when start is accepted
//                mem_rd, mem_addr,    scratch memory read port; mem_q is
//                mem_q                valid one cycle after mem_rd
//                in_w, inst_w         data and instruction to the mac_row
//                row_valid            valid vector from the mac_row
//                busy, done, err      job status
//                out_cnt              results counted in the current job
//
//  Revision    : 1.0  initial release
// ============================================================================
module mac_row_ctrl #(
    parameter int BW        = 4,
    parameter int COL       = 8,
    parameter int ADDR_BW   = 8,
    parameter int LEN_BW    = 8,
    parameter int DRAIN_MAX = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_BW-1:0]  len,
    input  logic [ADDR_BW-1:0] w_base,
    input  logic [ADDR_BW-1:0] x_base,
    output logic               mem_rd,
    output logic [ADDR_BW-1:0] mem_addr,
    input  logic [BW-1:0]      mem_q,
    output logic [BW-1:0]      in_w,
    output logic [1:0]         inst_w,
    input  logic [COL-1:0]     row_valid,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LEN_BW-1:0]  out_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_k_w = (COL > 1)       ? $clog2(COL)       : 1;
    localparam int c_d_w = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    localparam logic [c_k_w-1:0]  c_k_last   = c_k_w'(COL - 1);
    localparam logic [c_k_w-1:0]  c_k_one    = c_k_w'(1);
    localparam logic [c_d_w-1:0]  c_d_last   = c_d_w'(DRAIN_MAX - 1);
    localparam logic [c_d_w-1:0]  c_d_one    = c_d_w'(1);
    localparam logic [LEN_BW-1:0] c_len_one  = LEN_BW'(1);
    localparam logic [LEN_BW-1:0] c_out_max  = '1;

    localparam logic [1:0] c_inst_idle = 2'b00;
    localparam logic [1:0] c_inst_load = 2'b01;
    localparam logic [1:0] c_inst_exec = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and job context
    // ------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;

    logic [LEN_BW-1:0]   r_len;
    logic [ADDR_BW-1:0]  r_w_base;
    logic [ADDR_BW-1:0]  r_x_base;

    logic [c_k_w-1:0]    r_k;            // weight index within LOAD
    logic [c_k_w-1:0]    w_k_nxt;
    logic [LEN_BW-1:0]   r_j;            // activation index within EXEC
    logic [LEN_BW-1:0]   w_j_nxt;
    logic [c_d_w-1:0]    r_drain_cnt;    // cycles already spent in DRAIN
    logic [c_d_w-1:0]    w_drain_nxt;

    logic                r_err;
    logic                w_err_nxt;
    logic [LEN_BW-1:0]   r_out_cnt;

    // Phase pipe: which kind of read was issued last cycle. The memory
    // answers one cycle after the read, so this lines inst_w up with mem_q.
    logic                r_ph_load;
    logic                r_ph_exec;

    logic                w_accept;
    logic                w_len_met;
    logic                w_result;

    assign w_len_met = (r_out_cnt >= r_len);
    assign w_result  = busy && row_valid[COL-1];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_j_nxt     = r_j;
        w_drain_nxt = r_drain_cnt;
        w_err_nxt   = r_err;
        w_accept    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                    w_k_nxt     = '0;
                    w_err_nxt   = 1'b0;
                end
            end

            S_LOAD: begin
                if (r_k == c_k_last) begin
                    // Activation reads follow the last weight read directly.
                    w_j_nxt     = '0;
                    w_drain_nxt = '0;
                    w_state_nxt = (r_len != '0) ? S_EXEC : S_DRAIN;
                end else begin
                    w_k_nxt = r_k + c_k_one;
                end
            end

            S_EXEC: begin
                // Only entered with r_len != 0, so r_len - 1 cannot wrap here.
                if (r_j == (r_len - c_len_one)) begin
                    w_drain_nxt = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_j_nxt = r_j + c_len_one;
                end
            end

            S_DRAIN: begin
                // A full result count wins over a timeout in the same cycle.
                if (w_len_met) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (r_drain_cnt == c_d_last) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_nxt = r_drain_cnt + c_d_one;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_w_base    <= '0;
            r_x_base    <= '0;
            r_k         <= '0;
            r_j         <= '0;
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
            r_out_cnt   <= '0;
            r_ph_load   <= 1'b0;
            r_ph_exec   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_j         <= w_j_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_err       <= w_err_nxt;
            r_ph_load   <= (r_state == S_LOAD);
            r_ph_exec   <= (r_state == S_EXEC);

            if (w_accept) begin
                r_len     <= len;
                r_w_base  <= w_base;
                r_x_base  <= x_base;
                r_out_cnt <= '0;
            end else if (w_result && (r_out_cnt != c_out_max)) begin
                // Saturating; holds after done until the next accepted start.
                r_out_cnt <= r_out_cnt + c_len_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy   = (r_state == S_LOAD) || (r_state == S_EXEC) ||
                    (r_state == S_DRAIN);
    assign done   = (r_state == S_DONE);
    assign mem_rd = (r_state == S_LOAD) || (r_state == S_EXEC);

    // Base + index wraps naturally modulo 2^ADDR_BW.
    always_comb begin
        mem_addr = '0;
        if (r_state == S_LOAD) begin
            mem_addr = r_w_base + ADDR_BW'(r_k);
        end else if (r_state == S_EXEC) begin
            mem_addr = r_x_base + ADDR_BW'(r_j);
        end
    end

    always_comb begin
        inst_w = c_inst_idle;
        in_w   = '0;
        if (r_ph_load) begin
            inst_w = c_inst_load;
            in_w   = mem_q;
        end else if (r_ph_exec) begin
            inst_w = c_inst_exec;
            in_w   = mem_q;
        end
    end

    assign err     = r_err;
    assign out_cnt = r_out_cnt;

endmodule
`default_nettype wire
